aggregate_stream: RTL

- Parametrised successor to the single-word aggregator.
- Sits after the firewall in the RMII receive path and accepts the post-firewall dibit stream (axiiv/axiid).
- Strips the trailing FCS_BITS of every frame and packs the remaining payload into WORD_BITS-wide words.
- Emits every payload word, not only the first, with last-word, valid-bit-count and truncation flags, so downstream logic can consume arbitrary-length messages.

---
 rtl/aggregate_stream_if.sv | 26 ++
 rtl/aggregate_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aggregate_stream_if.sv
// Stream bundle for aggregate_stream: dibit input side and word output side.
// master is the aggregator's view, slave is the producer/consumer's view.
interface aggregate_stream_if #(
  parameter int unsigned WORD_BITS = 32
) ();
  localparam int unsigned CntW = $clog2(WORD_BITS + 1);

  logic                 axiiv;
  logic [1:0]           axiid;
  logic                 axiov;
  logic [WORD_BITS-1:0] axiod;
  logic [CntW-1:0]      axiocnt;
  logic                 axiol;
  logic                 axiotrunc;
  logic                 axioerr;

  modport master (
    input  axiiv, axiid,
    output axiov, axiod, axiocnt, axiol, axiotrunc, axioerr
  );

  modport slave (
    output axiiv, axiid,
    input  axiov, axiod, axiocnt, axiol, axiotrunc, axioerr
  );
endinterface

// File: rtl/aggregate_stream.sv
// Packs the post-firewall RMII dibit stream into words, dropping the trailing FCS.
// Optional CRC-32 check of each frame is enabled by defining AGGREGATE_STREAM_FCS_CHECK_EN.
module aggregate_stream #(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned FCS_BITS  = 32,
  parameter int unsigned MAX_WORDS = 16
) (
  input logic                clk,
  input logic                rst,
  aggregate_stream_if.master bus
);
  localparam int unsigned Dibits = FCS_BITS / 2;
  localparam int unsigned FillW  = $clog2(Dibits + 1);
  localparam int unsigned AccW   = $clog2(WORD_BITS / 2 + 1);
  localparam int unsigned WordsW = $clog2(MAX_WORDS + 1);
  localparam int unsigned CntW   = $clog2(WORD_BITS + 1);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StFrame} state_e;

  state_e               state_q, state_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [FCS_BITS-1:0]  dl_q, dl_d;
  logic [WORD_BITS-1:0] acc_q, acc_d;
  logic [AccW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [WORD_BITS-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [WordsW-1:0]    words_q, words_d;
  logic                 trunc_q, trunc_d;

  logic                 ov_q, ov_d, ol_q, ol_d, otrunc_q, otrunc_d, oerr_q, oerr_d;
  logic [WORD_BITS-1:0] od_q, od_d;
  logic [CntW-1:0]      ocnt_q, ocnt_d;

  logic                 take, frame_end, crc_bad;
  logic [1:0]           pop;
  logic [WORD_BITS-1:0] word;
  logic [CntW-1:0]      shamt;

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    dl_d       = dl_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    words_d    = words_q;
    trunc_d    = trunc_q;
    ov_d       = 1'b0;
    od_d       = '0;
    ocnt_d     = '0;
    ol_d       = 1'b0;
    otrunc_d   = 1'b0;
    oerr_d     = 1'b0;
    take       = 1'b0;
    frame_end  = 1'b0;
    pop        = dl_q[FCS_BITS-1 -: 2];
    word       = (acc_q << 2) | WORD_BITS'(pop);
    shamt      = CntW'(WORD_BITS) - CntW'({acc_cnt_q, 1'b0});

    unique case (state_q)
      StWaitIdle: if (!bus.axiiv) state_d = StIdle;
      StIdle: begin
        if (bus.axiiv) begin
          state_d = StFrame;
          take    = 1'b1;
        end
      end
      StFrame: begin
        if (bus.axiiv) begin
          take = 1'b1;
        end else begin
          state_d   = StIdle;
          frame_end = 1'b1;
        end
      end
      default: state_d = StWaitIdle;
    endcase

    if (take) begin
      dl_d = (dl_q << 2) | FCS_BITS'(bus.axiid);
      if (fill_q < FillW'(Dibits)) begin
        fill_d = fill_q + 1'b1;
      end else if (words_q == WordsW'(MAX_WORDS)) begin
        trunc_d = 1'b1;
      end else begin
        // A further payload dibit proves the held word is not the last one.
        if (hold_vld_q) begin
          ov_d       = 1'b1;
          od_d       = hold_q;
          ocnt_d     = CntW'(WORD_BITS);
          hold_vld_d = 1'b0;
        end
        if (acc_cnt_q == AccW'(WORD_BITS / 2 - 1)) begin
          hold_d     = word;
          hold_vld_d = 1'b1;
          acc_d      = '0;
          acc_cnt_d  = '0;
          words_d    = words_q + 1'b1;
        end else begin
          acc_d     = word;
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
    end

    if (frame_end) begin
      // A non-empty accumulator implies the held word was already released.
      if (acc_cnt_q != '0) begin
        ov_d     = 1'b1;
        od_d     = acc_q << shamt;
        ocnt_d   = CntW'({acc_cnt_q, 1'b0});
        ol_d     = 1'b1;
        otrunc_d = trunc_q;
        oerr_d   = crc_bad;
      end else if (hold_vld_q) begin
        ov_d     = 1'b1;
        od_d     = hold_q;
        ocnt_d   = CntW'(WORD_BITS);
        ol_d     = 1'b1;
        otrunc_d = trunc_q;
        oerr_d   = crc_bad;
      end
      fill_d     = '0;
      dl_d       = '0;
      acc_d      = '0;
      acc_cnt_d  = '0;
      hold_vld_d = 1'b0;
      words_d    = '0;
      trunc_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWaitIdle;
      fill_q     <= '0;
      dl_q       <= '0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      words_q    <= '0;
      trunc_q    <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      ocnt_q     <= '0;
      ol_q       <= 1'b0;
      otrunc_q   <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      dl_q       <= dl_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      words_q    <= words_d;
      trunc_q    <= trunc_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      ocnt_q     <= ocnt_d;
      ol_q       <= ol_d;
      otrunc_q   <= otrunc_d;
      oerr_q     <= oerr_d;
    end
  end

`ifdef AGGREGATE_STREAM_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  // MSB-first form of the Ethernet CRC, so a good frame leaves 0xC704DD7B.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (take)      crc_d = crc_step(crc_step(crc_q, bus.axiid[1]), bus.axiid[0]);
    if (frame_end) crc_d = '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= '1;
    else      crc_q <= crc_d;
  end

  assign crc_bad = (crc_q != 32'hC704_DD7B);
`else
  assign crc_bad = 1'b0;
`endif

  assign bus.axiov     = ov_q;
  assign bus.axiod     = od_q;
  assign bus.axiocnt   = ocnt_q;
  assign bus.axiol     = ol_q;
  assign bus.axiotrunc = otrunc_q;
  assign bus.axioerr   = oerr_q;
endmodule
